// File: rtl/adc_range_monitor_pkg.sv
// Shared types and helpers for the ADC range monitor: readout field codes,
// EMPTY accumulator values and a saturating adder.
package adc_monitor_pkg;

    typedef enum logic [1:0] {
        FIELD_MIN   = 2'd0,
        FIELD_MAX   = 2'd1,
        FIELD_CLIP  = 2'd2,
        FIELD_COUNT = 2'd3
    } readField_e;

    // EMPTY min is the most positive sample so the first real sample always replaces it
    function automatic int emptyMin(input int adcWidth);
        return (1 << (adcWidth - 1)) - 1;
    endfunction

    function automatic int emptyMax(input int adcWidth);
        return -(1 << (adcWidth - 1));
    endfunction

    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] maxVal);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, maxVal}) ? maxVal : sum[31:0];
    endfunction

endpackage

// File: rtl/adc_range_monitor_if.sv
// ADC sample stream plus result readout port of the range monitor.
interface adc_range_monitor_if #(
    parameter int AXI_CHANNEL_COUNT     = 8,
    parameter int AXI_SAMPLES_PER_CLOCK = 4,
    parameter int AXI_SAMPLE_WIDTH      = 16
);
    localparam int DATA_WIDTH = AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH;
    localparam int CH_SEL_WIDTH = (AXI_CHANNEL_COUNT > 1) ? $clog2(AXI_CHANNEL_COUNT) : 1;

    logic                    axiValid;
    logic [DATA_WIDTH-1:0]   axiData;
    logic [CH_SEL_WIDTH-1:0] readChannel;
    logic [1:0]              readField;
    logic [31:0]             readData;
    logic                    resultsStrobe;
    logic [7:0]              resultsSeq;

    modport master (
        output axiValid, axiData, readChannel, readField,
        input  readData, resultsStrobe, resultsSeq
    );

    modport slave (
        input  axiValid, axiData, readChannel, readField,
        output readData, resultsStrobe, resultsSeq
    );

endinterface

// File: rtl/adc_range_monitor_lane_reduce.sv
// Per-channel first stage: reduces one beat of lanes to min, max and the
// number of lanes at or beyond a clip threshold, registered on valid beats.
module adc_lane_reduce
    import adc_monitor_pkg::*;
#(
    parameter int SPC             = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int ADC_WIDTH       = 14,
    parameter int CLIP_LANE_WIDTH = $clog2(SPC + 1)
) (
    input  logic                              adcClk,
    input  logic                              adcReset,
    input  logic                              beatValid,
    input  logic [SPC*SAMPLE_WIDTH-1:0]       laneData,
    input  logic signed [ADC_WIDTH-1:0]       clipHi,
    input  logic signed [ADC_WIDTH-1:0]       clipLo,
    output logic signed [ADC_WIDTH-1:0]       laneMin,
    output logic signed [ADC_WIDTH-1:0]       laneMax,
    output logic [CLIP_LANE_WIDTH-1:0]        clipLanes
);
    localparam int PAD = SAMPLE_WIDTH - ADC_WIDTH;
    localparam logic signed [ADC_WIDTH-1:0] EMPTY_MIN = ADC_WIDTH'(emptyMin(ADC_WIDTH));
    localparam logic signed [ADC_WIDTH-1:0] EMPTY_MAX = ADC_WIDTH'(emptyMax(ADC_WIDTH));

    logic signed [ADC_WIDTH-1:0] sample [SPC];
    logic signed [ADC_WIDTH-1:0] redMin;
    logic signed [ADC_WIDTH-1:0] redMax;
    logic [CLIP_LANE_WIDTH-1:0]  redClip;

    // Samples are left-justified; the LSB padding below the ADC bits is don't-care
    for (genvar s = 0; s < SPC; s++) begin : g_lane
        assign sample[s] = $signed(laneData[s*SAMPLE_WIDTH + PAD +: ADC_WIDTH]);
    end

    if (PAD > 0) begin : g_pad
        logic [SPC*PAD-1:0] unusedPad;
        for (genvar s = 0; s < SPC; s++) begin : g_padLane
            assign unusedPad[s*PAD +: PAD] = laneData[s*SAMPLE_WIDTH +: PAD];
        end
    end

    always_comb begin
        redMin  = sample[0];
        redMax  = sample[0];
        redClip = '0;
        for (int s = 0; s < SPC; s++) begin
            if (sample[s] < redMin) redMin = sample[s];
            if (sample[s] > redMax) redMax = sample[s];
            if ((sample[s] >= clipHi) || (sample[s] <= clipLo))
                redClip = redClip + CLIP_LANE_WIDTH'(1);
        end
    end

    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            laneMin   <= EMPTY_MIN;
            laneMax   <= EMPTY_MAX;
            clipLanes <= '0;
        end else if (beatValid) begin
            laneMin   <= redMin;
            laneMax   <= redMax;
            clipLanes <= redClip;
        end
    end

endmodule

// File: rtl/adc_range_monitor.sv
// Windowed per-channel min/max/clip monitor on the ADC stream with a
// double-buffered result bank and a registered random-access readout.
module adc_range_monitor
    import adc_monitor_pkg::*;
#(
    parameter int AXI_CHANNEL_COUNT     = 8,
    parameter int AXI_SAMPLES_PER_CLOCK = 4,
    parameter int AXI_SAMPLE_WIDTH      = 16,
    parameter int ADC_WIDTH             = 14,
    parameter int WINDOW_WIDTH          = 24,
    parameter int COUNT_WIDTH           = 16
) (
    input  logic                        adcClk,
    input  logic                        adcReset,
    adc_range_monitor_if.slave          bus,
    input  logic                        autoMode,
    input  logic [WINDOW_WIDTH-1:0]     windowLength,
    input  logic                        latchStrobe,
    input  logic signed [ADC_WIDTH-1:0] clipHi,
    input  logic signed [ADC_WIDTH-1:0] clipLo
);
    localparam int CH   = AXI_CHANNEL_COUNT;
    localparam int SPC  = AXI_SAMPLES_PER_CLOCK;
    localparam int SW   = AXI_SAMPLE_WIDTH;
    localparam int CLW  = $clog2(SPC + 1);
    localparam logic signed [ADC_WIDTH-1:0] EMPTY_MIN = ADC_WIDTH'(emptyMin(ADC_WIDTH));
    localparam logic signed [ADC_WIDTH-1:0] EMPTY_MAX = ADC_WIDTH'(emptyMax(ADC_WIDTH));
    localparam logic [COUNT_WIDTH-1:0]  CLIP_MAX   = '1;
    localparam logic [WINDOW_WIDTH-1:0] WINDOW_MAX = '1;

    logic [WINDOW_WIDTH-1:0] validCnt;
    logic                    autoHit;
    logic                    closeReq;
    logic                    s1Valid;
    logic                    s1Close;

    logic signed [ADC_WIDTH-1:0] laneMin [CH];
    logic signed [ADC_WIDTH-1:0] laneMax [CH];
    logic [CLW-1:0]              laneClip [CH];

    logic signed [ADC_WIDTH-1:0] accMin [CH];
    logic signed [ADC_WIDTH-1:0] accMax [CH];
    logic [COUNT_WIDTH-1:0]      accClip [CH];
    logic [WINDOW_WIDTH-1:0]     accCount;
    logic signed [ADC_WIDTH-1:0] nxtMin [CH];
    logic signed [ADC_WIDTH-1:0] nxtMax [CH];
    logic [COUNT_WIDTH-1:0]      nxtClip [CH];
    logic [WINDOW_WIDTH-1:0]     nxtCount;

    logic signed [ADC_WIDTH-1:0] bankMin [CH];
    logic signed [ADC_WIDTH-1:0] bankMax [CH];
    logic [COUNT_WIDTH-1:0]      bankClip [CH];
    logic [WINDOW_WIDTH-1:0]     bankCount;

    logic        strobeReg;
    logic [7:0]  seqReg;
    logic [31:0] readReg;

    // >= rather than == so shrinking windowLength below the count closes on the next beat
    assign autoHit  = autoMode && (windowLength != '0) && bus.axiValid &&
                      (validCnt >= windowLength - WINDOW_WIDTH'(1));
    assign closeReq = latchStrobe || autoHit;

    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            validCnt <= '0;
            s1Valid  <= 1'b0;
            s1Close  <= 1'b0;
        end else begin
            s1Valid <= bus.axiValid;
            s1Close <= closeReq;
            if (closeReq)
                validCnt <= '0;
            else if (bus.axiValid && (validCnt != WINDOW_MAX))
                validCnt <= validCnt + WINDOW_WIDTH'(1);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        adc_lane_reduce #(
            .SPC             (SPC),
            .SAMPLE_WIDTH    (SW),
            .ADC_WIDTH       (ADC_WIDTH),
            .CLIP_LANE_WIDTH (CLW)
        ) u_reduce (
            .adcClk    (adcClk),
            .adcReset  (adcReset),
            .beatValid (bus.axiValid),
            .laneData  (bus.axiData[c*SPC*SW +: SPC*SW]),
            .clipHi    (clipHi),
            .clipLo    (clipLo),
            .laneMin   (laneMin[c]),
            .laneMax   (laneMax[c]),
            .clipLanes (laneClip[c])
        );
    end

    always_comb begin
        nxtCount = accCount;
        if (s1Valid)
            nxtCount = WINDOW_WIDTH'(satAdd(32'(accCount), 32'd1, 32'(WINDOW_MAX)));
        for (int c = 0; c < CH; c++) begin
            nxtMin[c]  = accMin[c];
            nxtMax[c]  = accMax[c];
            nxtClip[c] = accClip[c];
            if (s1Valid) begin
                if (laneMin[c] < accMin[c]) nxtMin[c] = laneMin[c];
                if (laneMax[c] > accMax[c]) nxtMax[c] = laneMax[c];
                nxtClip[c] = COUNT_WIDTH'(satAdd(32'(accClip[c]), 32'(laneClip[c]), 32'(CLIP_MAX)));
            end
        end
    end

    // The closing beat's contribution goes to the bank; accumulators restart EMPTY
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            for (int c = 0; c < CH; c++) begin
                accMin[c]   <= EMPTY_MIN;
                accMax[c]   <= EMPTY_MAX;
                accClip[c]  <= '0;
                bankMin[c]  <= EMPTY_MIN;
                bankMax[c]  <= EMPTY_MAX;
                bankClip[c] <= '0;
            end
            accCount  <= '0;
            bankCount <= '0;
            strobeReg <= 1'b0;
            seqReg    <= '0;
        end else begin
            strobeReg <= s1Close;
            if (s1Close) begin
                for (int c = 0; c < CH; c++) begin
                    bankMin[c]  <= nxtMin[c];
                    bankMax[c]  <= nxtMax[c];
                    bankClip[c] <= nxtClip[c];
                    accMin[c]   <= EMPTY_MIN;
                    accMax[c]   <= EMPTY_MAX;
                    accClip[c]  <= '0;
                end
                bankCount <= nxtCount;
                accCount  <= '0;
                seqReg    <= seqReg + 8'd1;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    accMin[c]  <= nxtMin[c];
                    accMax[c]  <= nxtMax[c];
                    accClip[c] <= nxtClip[c];
                end
                accCount <= nxtCount;
            end
        end
    end

    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            readReg <= '0;
        end else begin
            readReg <= '0;
            if (32'(bus.readChannel) < 32'(CH)) begin
                case (readField_e'(bus.readField))
                    FIELD_MIN:   readReg <= {{(32-ADC_WIDTH){bankMin[bus.readChannel][ADC_WIDTH-1]}},
                                             bankMin[bus.readChannel]};
                    FIELD_MAX:   readReg <= {{(32-ADC_WIDTH){bankMax[bus.readChannel][ADC_WIDTH-1]}},
                                             bankMax[bus.readChannel]};
                    FIELD_CLIP:  readReg <= 32'(bankClip[bus.readChannel]);
                    FIELD_COUNT: readReg <= 32'(bankCount);
                    default:     readReg <= '0;
                endcase
            end
        end
    end

    assign bus.readData      = readReg;
    assign bus.resultsStrobe = strobeReg;
    assign bus.resultsSeq    = seqReg;

endmodule

// File: tb/tb_adc_range_monitor.sv
// Randomized and directed bench for adc_range_monitor against a window-level
// reference model (sample lists reduced with plain arithmetic at close time).
module tb_adc_range_monitor;
    localparam int CH   = 2;
    localparam int SPC  = 2;
    localparam int SW   = 16;
    localparam int AW   = 14;
    localparam int WW   = 24;
    localparam int CW   = 4;
    localparam int EMIN = 8191;
    localparam int EMAX = -8192;
    localparam int CSAT = 15;

    logic adcClk = 1'b0;
    logic adcReset = 1'b1;
    logic autoMode = 1'b0;
    logic [WW-1:0] windowLength = '0;
    logic latchStrobe = 1'b0;
    logic signed [AW-1:0] clipHi = '0;
    logic signed [AW-1:0] clipLo = '0;

    always #5 adcClk = ~adcClk;

    adc_range_monitor_if #(
        .AXI_CHANNEL_COUNT(CH), .AXI_SAMPLES_PER_CLOCK(SPC), .AXI_SAMPLE_WIDTH(SW)
    ) bus ();

    adc_range_monitor #(
        .AXI_CHANNEL_COUNT(CH), .AXI_SAMPLES_PER_CLOCK(SPC), .AXI_SAMPLE_WIDTH(SW),
        .ADC_WIDTH(AW), .WINDOW_WIDTH(WW), .COUNT_WIDTH(CW)
    ) dut (
        .adcClk(adcClk), .adcReset(adcReset), .bus(bus.slave),
        .autoMode(autoMode), .windowLength(windowLength), .latchStrobe(latchStrobe),
        .clipHi(clipHi), .clipLo(clipLo)
    );

    int errCount = 0;
    int checkCount = 0;

    // Reference model state
    int laneVal [CH][SPC];
    int winSamples [CH][$];
    int winClip [CH];
    int winBeats;
    int vcnt;
    int hiI, loI;
    int bMin [CH], bMax [CH], bClip [CH], bCnt;
    int pMin [CH], pMax [CH], pClip [CH], pCnt;
    bit pipeV;
    int seq;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expRead(input int ch, input int f);
        case (f)
            0:       return 32'(bMin[ch]);
            1:       return 32'(bMax[ch]);
            2:       return 32'(bClip[ch]);
            default: return 32'(bCnt);
        endcase
    endfunction

    task automatic clearWindow();
        for (int c = 0; c < CH; c++) begin
            winSamples[c].delete();
            winClip[c] = 0;
        end
        winBeats = 0;
    endtask

    task automatic modelReset();
        clearWindow();
        for (int c = 0; c < CH; c++) begin
            bMin[c] = EMIN; bMax[c] = EMAX; bClip[c] = 0;
        end
        bCnt = 0; pipeV = 0; seq = 0; vcnt = 0;
    endtask

    task automatic setClip(input int hi, input int lo);
        hiI = hi; loI = lo;
        clipHi = AW'(hi); clipLo = AW'(lo);
    endtask

    task automatic setLanes(input int a0, input int a1, input int b0, input int b1);
        laneVal[0][0] = a0; laneVal[0][1] = a1;
        laneVal[1][0] = b0; laneVal[1][1] = b1;
    endtask

    task automatic randLanes();
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < SPC; s++)
                case ($urandom_range(7))
                    0:       laneVal[c][s] = EMIN;
                    1:       laneVal[c][s] = EMAX;
                    default: laneVal[c][s] = int'($urandom_range(16383)) - 8192;
                endcase
    endtask

    // One clock: drive beat/close/read select, then check outputs after the edge
    task automatic step(input bit v, input bit ls, input int rc, input int rf);
        logic [31:0] er;
        bit hit, cl;
        int i, mn, mx;
        bus.readChannel = 1'(rc);
        bus.readField   = 2'(rf);
        er = expRead(rc, rf);
        hit = autoMode && (windowLength != 0) && v && (vcnt >= int'(windowLength) - 1);
        cl  = ls || hit;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < SPC; s++) begin
                i = c * SPC + s;
                bus.axiData[i*SW +: SW] = {AW'(laneVal[c][s]), 2'($urandom_range(3))};
                if (v) begin
                    winSamples[c].push_back(laneVal[c][s]);
                    if (laneVal[c][s] >= hiI || laneVal[c][s] <= loI) winClip[c]++;
                end
            end
        if (v) winBeats++;
        bus.axiValid = v;
        latchStrobe  = ls;
        @(posedge adcClk);
        #1;
        checkValue("readData", bus.readData, er);
        checkValue("resultsStrobe", 32'(bus.resultsStrobe), 32'(pipeV));
        if (pipeV) begin
            for (int c = 0; c < CH; c++) begin
                bMin[c] = pMin[c]; bMax[c] = pMax[c]; bClip[c] = pClip[c];
            end
            bCnt = pCnt;
            seq = (seq + 1) % 256;
        end
        checkValue("resultsSeq", 32'(bus.resultsSeq), 32'(seq));
        pipeV = cl;
        if (cl) begin
            for (int c = 0; c < CH; c++) begin
                mn = EMIN; mx = EMAX;
                foreach (winSamples[c][k]) begin
                    if (winSamples[c][k] < mn) mn = winSamples[c][k];
                    if (winSamples[c][k] > mx) mx = winSamples[c][k];
                end
                pMin[c] = mn; pMax[c] = mx;
                pClip[c] = (winClip[c] > CSAT) ? CSAT : winClip[c];
            end
            pCnt = winBeats;
            clearWindow();
            vcnt = 0;
        end else if (v) begin
            vcnt++;
        end
        bus.axiValid = 1'b0;
        latchStrobe  = 1'b0;
    endtask

    task automatic stepR(input bit v, input bit ls);
        step(v, ls, int'($urandom_range(CH - 1)), int'($urandom_range(3)));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) stepR(1'b0, 1'b0);
    endtask

    task automatic readCheck(input string tag, input int ch, input int f, input logic [31:0] exp);
        step(1'b0, 1'b0, ch, f);
        checkValue(tag, bus.readData, exp);
    endtask

    task automatic doReset(input int cycles);
        adcReset = 1'b1;
        bus.axiValid = 1'b0;
        latchStrobe = 1'b0;
        repeat (cycles) @(posedge adcClk);
        #1;
        checkValue("rst_readData", bus.readData, 32'd0);
        checkValue("rst_strobe", 32'(bus.resultsStrobe), 32'd0);
        checkValue("rst_seq", 32'(bus.resultsSeq), 32'd0);
        adcReset = 1'b0;
        modelReset();
    endtask

    initial begin
        bus.axiValid = 1'b0;
        bus.axiData = '0;
        bus.readChannel = '0;
        bus.readField = '0;
        setLanes(0, 0, 0, 0);
        setClip(8000, -8000);
        modelReset();
        doReset(2);
        idle(2);

        // Auto window of 4 beats
        autoMode = 1'b1; windowLength = 24'd4;
        setLanes(100, -50, 11, 12);   stepR(1'b1, 1'b0);
        setLanes(7, 9, -20, 40);      stepR(1'b1, 1'b0);
        setLanes(-300, 2, 5, 5);      stepR(1'b1, 1'b0);
        setLanes(0, 0, 0, 1);         stepR(1'b1, 1'b0);
        checkValue("t1_noStrobeYet", 32'(bus.resultsStrobe), 32'd0);
        stepR(1'b0, 1'b0);
        checkValue("t1_strobe", 32'(bus.resultsStrobe), 32'd1);
        idle(2);
        readCheck("t1_min", 0, 0, 32'hFFFF_FED4);
        readCheck("t1_max", 0, 1, 32'd100);
        readCheck("t1_clip", 0, 2, 32'd0);
        readCheck("t1_count", 0, 3, 32'd4);
        checkValue("t1_seq", 32'(bus.resultsSeq), 32'd1);

        // Full-scale lanes on ch1, closed manually after 3 beats
        for (int k = 0; k < 3; k++) begin
            setLanes(0, 0, 8191, -8192);
            stepR(1'b1, 1'b0);
        end
        stepR(1'b0, 1'b1);
        idle(3);
        readCheck("t2_clip", 1, 2, 32'd6);
        readCheck("t2_max", 1, 1, 32'h0000_1FFF);
        readCheck("t2_min", 1, 0, 32'hFFFF_E000);
        readCheck("t2_count", 1, 3, 32'd3);

        // Manual close of an empty window
        autoMode = 1'b0;
        idle(3);
        stepR(1'b0, 1'b1);
        idle(3);
        readCheck("t3_min", 0, 0, 32'h0000_1FFF);
        readCheck("t3_max", 0, 1, 32'hFFFF_E000);
        readCheck("t3_count", 0, 3, 32'd0);
        checkValue("t3_seq", 32'(bus.resultsSeq), 32'd3);

        // Manual close coinciding with the auto boundary beat
        autoMode = 1'b1; windowLength = 24'd4;
        for (int k = 0; k < 3; k++) begin randLanes(); stepR(1'b1, 1'b0); end
        randLanes(); stepR(1'b1, 1'b1);
        idle(4);
        readCheck("t4_count", 1, 3, 32'd4);
        checkValue("t4_seq", 32'(bus.resultsSeq), 32'd4);

        // Clip counter saturation
        autoMode = 1'b0;
        for (int k = 0; k < 10; k++) begin
            setLanes(8191, -8192, 8000, -8000);
            stepR(1'b1, 1'b0);
        end
        stepR(1'b0, 1'b1);
        idle(3);
        readCheck("t5_clip0", 0, 2, 32'd15);
        readCheck("t5_clip1", 1, 2, 32'd15);

        // Reset in the middle of a window
        autoMode = 1'b1; windowLength = 24'd4;
        for (int k = 0; k < 2; k++) begin randLanes(); stepR(1'b1, 1'b0); end
        doReset(1);
        readCheck("t6_countEmpty", 0, 3, 32'd0);
        readCheck("t6_minEmpty", 1, 0, 32'h0000_1FFF);
        for (int k = 0; k < 4; k++) begin randLanes(); stepR(1'b1, 1'b0); end
        idle(3);
        readCheck("t6_count", 0, 3, 32'd4);
        checkValue("t6_seq", 32'(bus.resultsSeq), 32'd1);

        // Random traffic with on-the-fly mode, length and threshold changes
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(39) == 0) windowLength = WW'($urandom_range(6));
            if ($urandom_range(59) == 0) autoMode = ~autoMode;
            if ($urandom_range(99) == 0)
                setClip(int'($urandom_range(8191)), -int'($urandom_range(8192)));
            randLanes();
            stepR($urandom_range(3) != 0, $urandom_range(24) == 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/adc_range_monitor.md
Name: adc_range_monitor

Overview:
- Successor to the ADC range checker. Tracks per-channel min, max and clip-event count across all samples-per-clock lanes of the ADC AXI stream.
- Windows close either automatically, every N valid clocks, or manually on a strobe. Closed-window results are double-buffered into a result bank.
- The bank is read through a random-access readout port with 1-cycle latency; there is no shift register.
- Sits in the adcClk domain. CSR clock crossing is handled by the existing system-side register block.

Parameters:
- AXI_CHANNEL_COUNT, 8: number of ADC channels.
- AXI_SAMPLES_PER_CLOCK, 4: samples per channel per clock (lanes).
- AXI_SAMPLE_WIDTH, 16: bits per sample slot in axiData.
- ADC_WIDTH, 14: significant bits, left-justified (MSBs) in each slot, two's complement.
- WINDOW_WIDTH, 24: width of windowLength and of the valid-clock counter.
- COUNT_WIDTH, 16: clip counter width, saturating.
- DATA_WIDTH, AXI_CHANNEL_COUNT*AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH: derived.

Ports:
- adcClk  in  1  clock.
- adcReset  in  1  synchronous, active-high reset.
- axiValid  in  1  sample beat valid.
- axiData  in  DATA_WIDTH  lane i = c*AXI_SAMPLES_PER_CLOCK+s at bits [i*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH].
- autoMode  in  1  1 = close window every windowLength valid clocks.
- windowLength  in  WINDOW_WIDTH  valid clocks per window; 0 disables auto close.
- latchStrobe  in  1  manual window close (1-cycle pulse).
- clipHi  in  ADC_WIDTH  signed; a sample >= clipHi is a clip event.
- clipLo  in  ADC_WIDTH  signed; a sample <= clipLo is a clip event.
- readChannel  in  $clog2(AXI_CHANNEL_COUNT)  result select.
- readField  in  2  0=min, 1=max, 2=clip count, 3=window valid-clock count.
- readData  out  32  registered result.
- resultsStrobe  out  1  1-cycle pulse when the result bank updates.
- resultsSeq  out  8  increments (wrapping) on each bank update.

Behaviour:
- Reset:
  - readData=0, resultsStrobe=0, resultsSeq=0.
  - Accumulators and bank are set to EMPTY: min=+2^(ADC_WIDTH-1)-1, max=-2^(ADC_WIDTH-1), clip=0, count=0.
  - Reset mid-window discards the partial window with no strobe.
- Pipeline stage 1 (adc_lane_reduce): per channel, register the lane-min, lane-max and number of lanes clipping (0..SPC) for beats with axiValid=1. A close request registers alongside.
- Pipeline stage 2: accumulate.
  - min/max are signed compares.
  - clip += lane clip count, saturating at 2^COUNT_WIDTH-1.
  - count += 1 per valid beat, saturating at 2^WINDOW_WIDTH-1.
- Close conditions:
  - latchStrobe=1, or
  - autoMode=1, windowLength!=0, axiValid=1 and the valid-clock counter reaches windowLength-1 (counter resets to 0).
- A beat arriving in the same cycle as the close belongs to the closing window.
- On close (stage 2): copy accumulators, including that beat's contribution, into the bank. Restart the accumulators at EMPTY; the next beat starts the new window.
- resultsStrobe pulses and resultsSeq increments in the same cycle the bank is written, which is 2 cycles after the close input.
- A manual and an auto close in the same cycle produce a single close.
- A close with no valid beats writes the EMPTY values with count=0.
- windowLength or autoMode changes take effect for the counter immediately. If the counter is already >= a new nonzero windowLength, the window closes on the next valid beat.
- Readout:
  - readData registers on every clock from readChannel/readField.
  - min/max are sign-extended to 32 bits; clip and count are zero-extended.
  - A channel index >= AXI_CHANNEL_COUNT returns 0.
  - A read in the bank-write cycle returns the old value; the next cycle returns the new value.

Decomposition:
- Package adc_monitor_pkg holds:
  - field codes FIELD_MIN/MAX/CLIP/COUNT;
  - an EMPTY min/max constant function of ADC_WIDTH;
  - a saturating-add helper.
- Sub-module adc_lane_reduce: one per channel. It takes SPC lanes and clipHi/clipLo, and produces a registered min, max and clip-lane count.

Test Plan:
- Test parameters: CH=2, SPC=2, ADC_WIDTH=14, autoMode=1, windowLength=4, clipHi=8000, clipLo=-8000.
  - Stimulus: 4 valid beats, ch0 lanes {100,-50},{7,9},{-300,2},{0,0}.
  - Required: resultsStrobe 2 cycles after beat 4; ch0 min=-300, max=100, clip=0, count=4; resultsSeq=1.
- Lanes at 8191 and -8192 for 3 beats, both lanes of ch1 -> ch1 clip=6; readData for max=0x00001FFF, for min=0xFFFFE000.
- Manual mode: latchStrobe with axiValid=0 throughout the window -> bank min=8191, max=-8192, count=0; resultsSeq increments.
- latchStrobe in the same cycle as the auto boundary beat -> exactly one resultsStrobe; the boundary beat is counted in the closed window (count=4).
- COUNT_WIDTH=4 with clipping on all lanes for 10 beats -> clip count saturates at 15.
- adcReset asserted mid-window after 2 beats -> no strobe; readData=0 next cycle; bank reads EMPTY; the next window counts from 0.
